// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU functions, register ids,
// condition-code bit positions and the jXX/cmovXX condition table.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [3:0] RNONE = 4'hF;

    // CC is packed as {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    // Condition evaluation; unknown condition codes are never taken.
    function automatic logic cond_taken(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        logic res;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (ifun)
            C_ALWAYS: res = 1'b1;
            C_LE:     res = (sf ^ of) | zf;
            C_L:      res = sf ^ of;
            C_E:      res = zf;
            C_NE:     res = ~zf;
            C_GE:     res = ~(sf ^ of);
            C_G:      res = ~(sf ^ of) & ~zf;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic cond_legal(input logic [3:0] ifun);
        return ifun <= C_G;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational execute ALU: valE per icode/ifun plus the OPq flags.
// o_illegal covers unknown icodes and unknown OPq functions.
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   i_icode,
    input  logic [3:0]   i_ifun,
    input  logic [W-1:0] i_valA,
    input  logic [W-1:0] i_valB,
    input  logic [W-1:0] i_valC,
    output logic [W-1:0] o_valE,
    output logic         o_zf,
    output logic         o_sf,
    output logic         o_of,
    output logic         o_illegal
);

    localparam logic [W-1:0] WB = W'(W / 8);

    // Result select; arithmetic wraps modulo 2^W
    always_comb begin
        o_valE    = '0;
        o_illegal = 1'b0;
        case (i_icode)
            I_HALT, I_NOP, I_JXX: o_valE = '0;
            I_RRMOVQ:             o_valE = i_valA;
            I_IRMOVQ:             o_valE = i_valC;
            I_RMMOVQ, I_MRMOVQ:   o_valE = i_valB + i_valC;
            I_OPQ: begin
                case (i_ifun)
                    A_ADD:   o_valE = i_valB + i_valA;
                    A_SUB:   o_valE = i_valB - i_valA;
                    A_AND:   o_valE = i_valB & i_valA;
                    A_XOR:   o_valE = i_valB ^ i_valA;
                    default: o_illegal = 1'b1;
                endcase
            end
            I_CALL, I_PUSHQ:      o_valE = i_valB - WB;
            I_RET, I_POPQ:        o_valE = i_valB + WB;
            default:              o_illegal = 1'b1;
        endcase
    end

    // OPq flags; only meaningful when the caller writes CC for a legal OPq
    always_comb begin
        o_zf = (o_valE == '0);
        o_sf = o_valE[W-1];
        case (i_ifun)
            A_ADD:   o_of = (i_valA[W-1] == i_valB[W-1]) && (o_valE[W-1] != i_valB[W-1]);
            A_SUB:   o_of = (i_valA[W-1] != i_valB[W-1]) && (o_valE[W-1] != i_valB[W-1]);
            default: o_of = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_execute_stage.sv
// Y86 execute stage: ALU, condition-code register, condition evaluation and
// the E->M pipeline register with valid/ready flow control.
module pipe_execute_stage
    import y86_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    input  logic [3:0]   in_dstE,
    input  logic [3:0]   in_dstM,
    input  logic         cc_inhibit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_valE,
    output logic [W-1:0] out_valA,
    output logic [3:0]   out_dstE,
    output logic [3:0]   out_dstM,
    output logic         out_cnd,
    output logic         out_err,
    output logic [2:0]   cc
);

    logic [W-1:0] w_valE;
    logic         w_zf, w_sf, w_of, w_alu_illegal;
    logic         w_is_cond, w_cnd, w_err, w_accept, w_cc_we;
    logic [3:0]   w_dstE;

    logic         r_valid;
    logic [3:0]   r_icode;
    logic [W-1:0] r_valE;
    logic [W-1:0] r_valA;
    logic [3:0]   r_dstE;
    logic [3:0]   r_dstM;
    logic         r_cnd;
    logic         r_err;
    logic [2:0]   r_cc;

    y86_alu #(.W(W)) u_alu (
        .i_icode   (in_icode),
        .i_ifun    (in_ifun),
        .i_valA    (in_valA),
        .i_valB    (in_valB),
        .i_valC    (in_valC),
        .o_valE    (w_valE),
        .o_zf      (w_zf),
        .o_sf      (w_sf),
        .o_of      (w_of),
        .o_illegal (w_alu_illegal)
    );

    assign in_ready = !r_valid || out_ready;

    // Condition, error and CC-write decode; cnd uses CC as held before this accept
    always_comb begin
        w_is_cond = (in_icode == I_RRMOVQ) || (in_icode == I_JXX);
        w_cnd     = w_is_cond && cond_taken(in_ifun, r_cc);
        w_err     = w_alu_illegal || (w_is_cond && !cond_legal(in_ifun));
        w_dstE    = (in_icode == I_RRMOVQ && !w_cnd) ? RNONE : in_dstE;
        w_accept  = in_valid && in_ready;
        w_cc_we   = w_accept && (in_icode == I_OPQ) && !w_alu_illegal && !cc_inhibit;
    end

    // E->M register: load on accept, bubble on consume-only, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_icode <= '0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_cnd   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_icode <= in_icode;
            r_valE  <= w_valE;
            r_valA  <= in_valA;
            r_dstE  <= w_dstE;
            r_dstM  <= in_dstM;
            r_cnd   <= w_cnd;
            r_err   <= w_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Condition codes: written only by an accepted legal OPq when not inhibited
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cc <= CC_RESET;
        end else if (w_cc_we) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    assign out_valid = r_valid;
    assign out_icode = r_icode;
    assign out_valE  = r_valE;
    assign out_valA  = r_valA;
    assign out_dstE  = r_dstE;
    assign out_dstM  = r_dstM;
    assign out_cnd   = r_cnd;
    assign out_err   = r_err;
    assign cc        = r_cc;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Scoreboard bench for pipe_execute_stage: stimulus pushes reference-model
// results into a queue, a negedge monitor compares whatever the DUT presents.
module tb_pipe_execute_stage;

    localparam int         W        = 64;
    localparam logic [2:0] CC_RESET = 3'b100;
    localparam logic [W-1:0] WB     = 64'(W / 8);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_icode, in_ifun;
    logic [W-1:0] in_valA, in_valB, in_valC;
    logic [3:0]   in_dstE, in_dstM;
    logic         cc_inhibit;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_icode;
    logic [W-1:0] out_valE, out_valA;
    logic [3:0]   out_dstE, out_dstM;
    logic         out_cnd, out_err;
    logic [2:0]   cc;

    typedef struct {
        logic [3:0]   icode;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic         cnd;
        logic         err;
        logic [2:0]   cc;
    } exp_t;

    exp_t       sbq[$];
    logic [2:0] model_cc;
    int         checks = 0;
    int         errors = 0;
    logic       rand_ready = 1'b0;

    pipe_execute_stage #(.W(W), .CC_RESET(CC_RESET)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_icode   (in_icode),
        .in_ifun    (in_ifun),
        .in_valA    (in_valA),
        .in_valB    (in_valB),
        .in_valC    (in_valC),
        .in_dstE    (in_dstE),
        .in_dstM    (in_dstM),
        .cc_inhibit (cc_inhibit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_icode  (out_icode),
        .out_valE   (out_valE),
        .out_valA   (out_valA),
        .out_dstE   (out_dstE),
        .out_dstM   (out_dstM),
        .out_cnd    (out_cnd),
        .out_err    (out_err),
        .cc         (cc)
    );

    always #5 clk = ~clk;

    // Reference model: one accepted instruction, updating model_cc as a side effect.
    function automatic exp_t model_step(input logic [3:0] ic, input logic [3:0] ifn,
                                        input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c, input logic [3:0] de,
                                        input logic [3:0] dm, input logic inh);
        exp_t e;
        logic signed [W:0] wide;
        logic zf, sf, of, lt;
        zf = model_cc[2];
        sf = model_cc[1];
        of = model_cc[0];
        lt = (sf != of);
        e.icode = ic;
        e.valA  = a;
        e.dstM  = dm;
        e.valE  = '0;
        e.cnd   = 1'b0;
        e.err   = (ic > 4'hB) || (ic == 4'h6 && ifn > 4'h3) ||
                  ((ic == 4'h2 || ic == 4'h7) && ifn > 4'h6);
        case (ic)
            4'h2:       e.valE = a;
            4'h3:       e.valE = c;
            4'h4, 4'h5: e.valE = b + c;
            4'h6: begin
                if (ifn == 0)      e.valE = b + a;
                else if (ifn == 1) e.valE = b - a;
                else if (ifn == 2) e.valE = b & a;
                else if (ifn == 3) e.valE = b ^ a;
            end
            4'h8, 4'hA: e.valE = b - WB;
            4'h9, 4'hB: e.valE = b + WB;
            default:    e.valE = '0;
        endcase
        if (ic == 4'h2 || ic == 4'h7) begin
            case (ifn)
                4'h0:    e.cnd = 1'b1;
                4'h1:    e.cnd = lt || zf;
                4'h2:    e.cnd = lt;
                4'h3:    e.cnd = zf;
                4'h4:    e.cnd = !zf;
                4'h5:    e.cnd = !lt;
                4'h6:    e.cnd = !lt && !zf;
                default: e.cnd = 1'b0;
            endcase
        end
        e.dstE = (ic == 4'h2 && !e.cnd) ? 4'hF : de;
        if (ic == 4'h6 && ifn <= 4'h3 && !inh) begin
            // overflow = the exact signed result does not fit in W bits
            if (ifn == 0)      wide = $signed({b[W-1], b}) + $signed({a[W-1], a});
            else if (ifn == 1) wide = $signed({b[W-1], b}) - $signed({a[W-1], a});
            else               wide = '0;
            model_cc = {e.valE == '0, e.valE[W-1], (ifn <= 1) ? (wide[W] != wide[W-1]) : 1'b0};
        end
        e.cc = model_cc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare presented bundle against head of scoreboard; pop on transfer
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: out_valid=1 icode=%0h valE=0x%0h with nothing expected",
                         out_icode, out_valE);
            end else begin
                if ({out_icode, out_valE, out_valA, out_dstE, out_dstM, out_cnd, out_err, cc} !==
                    {sbq[0].icode, sbq[0].valE, sbq[0].valA, sbq[0].dstE, sbq[0].dstM,
                     sbq[0].cnd, sbq[0].err, sbq[0].cc}) begin
                    errors++;
                    $display("FAIL out_bundle: got icode=%0h valE=0x%0h valA=0x%0h dstE=%0h dstM=%0h cnd=%0b err=%0b cc=%03b expected icode=%0h valE=0x%0h valA=0x%0h dstE=%0h dstM=%0h cnd=%0b err=%0b cc=%03b",
                             out_icode, out_valE, out_valA, out_dstE, out_dstM, out_cnd, out_err, cc,
                             sbq[0].icode, sbq[0].valE, sbq[0].valA, sbq[0].dstE, sbq[0].dstM,
                             sbq[0].cnd, sbq[0].err, sbq[0].cc);
                end
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] de,
                        input logic [3:0] dm, input logic inh);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1; in_icode = ic; in_ifun = ifn;
        in_valA = a; in_valB = b; in_valC = c;
        in_dstE = de; in_dstM = dm; cc_inhibit = inh;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model_step(ic, ifn, a, b, c, de, dm, inh));
                acc = 1;
            end
            n++;
            tick();
        end
        in_valid = 1'b0;
        cc_inhibit = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bundles outstanding, expected 0", sbq.size());
        end
    endtask

    initial begin
        logic [3:0]   ic, ifn;
        logic [W-1:0] a, b, c;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cc_inhibit = 1'b0;
        in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
        in_dstE = 4'hF; in_dstM = 4'hF;
        model_cc = CC_RESET;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cc", cc, 3'b100);
        chk("rst_dstE", out_dstE, 4'hF);
        chk("rst_dstM", out_dstM, 4'hF);
        chk("rst_valE", out_valE, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // add / sub basics
        send(4'h6, 4'h0, 64'h31, 64'h45, 0, 4'h1, 4'hF, 0);
        drain();
        chk("add_cc", cc, 3'b000);
        send(4'h6, 4'h1, 64'h45, 64'h45, 0, 4'h1, 4'hF, 0);
        drain();
        chk("sub_zero_cc", cc, 3'b100);

        // large positive minus -5 overflows into the sign bit: SF=1, OF=1,
        // so le is not taken and g is taken
        send(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2, 4'hF, 0);
        drain();
        chk("sub_ovf_cc", cc, 3'b011);
        send(4'h2, 4'h1, 64'hAA, 0, 0, 4'h3, 4'hF, 0);
        send(4'h2, 4'h6, 64'hBB, 0, 0, 4'h3, 4'hF, 0);
        drain();

        // back-to-back OPq then jXX with the consumer always ready
        send(4'h6, 4'h1, 64'h10, 64'h10, 0, 4'h4, 4'hF, 0);
        send(4'h7, 4'h3, 0, 0, 64'h400, 4'hF, 4'hF, 0);
        send(4'h6, 4'h0, 64'h1, 64'h1, 0, 4'h4, 4'hF, 0);
        send(4'h7, 4'h3, 0, 0, 64'h400, 4'hF, 4'hF, 0);
        drain();

        // stall: held output, input blocked, CC untouched, then one transfer
        out_ready = 1'b0;
        send(4'h6, 4'h0, 64'h2, 64'h3, 0, 4'h5, 4'hF, 0);
        in_valid = 1'b1; in_icode = 4'h6; in_ifun = 4'h1;
        in_valA = 64'h9; in_valB = 64'h1; in_valC = 0; in_dstE = 4'h6; in_dstM = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_cc", cc, model_cc);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'h6, 4'h1, 64'h9, 64'h1, 0, 4'h6, 4'hF, 0);
        drain();
        repeat (3) tick();

        // inhibit, push/pop stack math, illegal encodings
        send(4'h6, 4'h3, 64'h6, 64'h6, 0, 4'h1, 4'hF, 1);
        drain();
        chk("inhibit_cc", cc, model_cc);
        send(4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4, 4'hF, 0);
        send(4'hB, 4'h0, 0, 64'h100, 0, 4'h4, 4'h3, 0);
        send(4'hC, 4'h0, 64'h1, 64'h2, 64'h3, 4'h1, 4'h2, 0);
        send(4'h6, 4'h5, 64'h1, 64'h2, 0, 4'h1, 4'hF, 0);
        send(4'h7, 4'h9, 0, 0, 64'h80, 4'hF, 4'hF, 0);
        drain();

        // randomized traffic with random backpressure and gaps
        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            ic  = 4'($urandom_range(0, 15));
            ifn = (ic == 4'h6) ? 4'($urandom_range(0, 4)) :
                  (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            c = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 255));
            send(ic, ifn, a, b, c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // reset while a bundle is stalled at the output
        out_ready = 1'b0;
        send(4'h6, 4'h0, 64'h1, 64'h1, 0, 4'h7, 4'hF, 0);
        @(negedge clk);
        chk("pre_rst_cc", cc, 3'b000);
        @(posedge clk); #1;
        reset = 1'b1;
        sbq.delete();
        model_cc = CC_RESET;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_cc", cc, CC_RESET);
        chk("rst2_dstE", out_dstE, 4'hF);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst2_dropped", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
